// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: runs one CPU load or store on an Avalon-style data memory bus.
// It builds the aligned address, lane enables and replicated write data, holds the request
// through waitrequest, and returns extended load data with misaligned/timeout qualifiers.
module mem_access_ctrl #(
   parameter int unsigned WAIT_LIMIT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [5:0]  opcode,
   input  logic [31:0] addr,
   input  logic [31:0] store_data,
   output logic        busy,
   output logic        done,
   output logic [31:0] load_data,
   output logic        misaligned,
   output logic        timeout,
   output logic [31:0] address,
   output logic        read,
   output logic        write,
   output logic [31:0] writedata,
   output logic [3:0]  byteenable,
   input  logic        waitrequest,
   input  logic [31:0] readdata
);

   localparam int unsigned CntW = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;

   localparam logic [5:0] OpLb  = 6'b100000;
   localparam logic [5:0] OpLh  = 6'b100001;
   localparam logic [5:0] OpLw  = 6'b100011;
   localparam logic [5:0] OpLbu = 6'b100100;
   localparam logic [5:0] OpLhu = 6'b100101;
   localparam logic [5:0] OpSb  = 6'b101000;
   localparam logic [5:0] OpSh  = 6'b101001;
   localparam logic [5:0] OpSw  = 6'b101011;

   typedef enum logic [1:0] {StIdle, StAccess, StFinish} state_e;

   state_e            state_q, state_d;
   logic [5:0]        op_q, op_d;
   logic [1:0]        lane_q, lane_d;
   logic [31:0]       address_q, address_d;
   logic [31:0]       writedata_q, writedata_d;
   logic [3:0]        byteenable_q, byteenable_d;
   logic              read_q, read_d;
   logic              write_q, write_d;
   logic [31:0]       load_data_q, load_data_d;
   logic              misaligned_q, misaligned_d;
   logic              timeout_q, timeout_d;
   logic [CntW-1:0]   wait_cnt_q, wait_cnt_d;

   logic              sup;
   logic              is_load;
   logic              aligned;
   logic [3:0]        be_new;
   logic [31:0]       wd_new;

   // Select the lane from the latched byte offset and extend per the load flavour.
   function automatic logic [31:0] extract(input logic [5:0] op, input logic [1:0] lane,
                                           input logic [31:0] data);
      logic [7:0]  b;
      logic [15:0] h;
      b = data[{lane, 3'b000} +: 8];
      h = lane[1] ? data[31:16] : data[15:0];
      case (op)
         OpLb:    extract = {{24{b[7]}}, b};
         OpLbu:   extract = {24'b0, b};
         OpLh:    extract = {{16{h[15]}}, h};
         OpLhu:   extract = {16'b0, h};
         default: extract = data;
      endcase
   endfunction

   // Decode the incoming opcode: size, alignment, lane enables and replicated write data.
   always_comb begin
      sup     = 1'b1;
      aligned = 1'b1;
      be_new  = 4'b0000;
      wd_new  = store_data;
      case (opcode)
         OpLb, OpLbu, OpSb: begin
            be_new = 4'b0001 << addr[1:0];
            wd_new = {4{store_data[7:0]}};
         end
         OpLh, OpLhu, OpSh: begin
            aligned = ~addr[0];
            be_new  = addr[1] ? 4'b1100 : 4'b0011;
            wd_new  = {2{store_data[15:0]}};
         end
         OpLw, OpSw: begin
            aligned = (addr[1:0] == 2'b00);
            be_new  = 4'b1111;
         end
         default: begin
            sup     = 1'b0;
            aligned = 1'b0;
         end
      endcase
      // Loads are 100xxx, stores 101xxx.
      is_load = sup & ~opcode[3];
   end

   // Next-state and datapath update for the IDLE -> ACCESS -> FINISH sequence.
   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      lane_d       = lane_q;
      address_d    = address_q;
      writedata_d  = writedata_q;
      byteenable_d = byteenable_q;
      read_d       = read_q;
      write_d      = write_q;
      load_data_d  = load_data_q;
      misaligned_d = misaligned_q;
      timeout_d    = timeout_q;
      wait_cnt_d   = wait_cnt_q;
      case (state_q)
         StIdle: begin
            if (start && sup) begin
               if (aligned) begin
                  state_d      = StAccess;
                  op_d         = opcode;
                  lane_d       = addr[1:0];
                  address_d    = {addr[31:2], 2'b00};
                  byteenable_d = be_new;
                  writedata_d  = wd_new;
                  read_d       = is_load;
                  write_d      = ~is_load;
                  wait_cnt_d   = '0;
               end else begin
                  state_d      = StFinish;
                  misaligned_d = 1'b1;
               end
            end
         end
         StAccess: begin
            // Completion wins over timeout when both could fire in the same cycle.
            if (!waitrequest) begin
               read_d  = 1'b0;
               write_d = 1'b0;
               state_d = StFinish;
               if (read_q) begin
                  load_data_d = extract(op_q, lane_q, readdata);
               end
            end else if ((WAIT_LIMIT != 0) && (wait_cnt_q == CntW'(WAIT_LIMIT))) begin
               read_d    = 1'b0;
               write_d   = 1'b0;
               timeout_d = 1'b1;
               state_d   = StFinish;
            end else begin
               wait_cnt_d = wait_cnt_q + CntW'(1);
            end
         end
         StFinish: begin
            state_d      = StIdle;
            misaligned_d = 1'b0;
            timeout_d    = 1'b0;
            wait_cnt_d   = '0;
         end
         default: state_d = StIdle;
      endcase
   end

   // State and output registers; reset drops the bus strobes immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= StIdle;
         op_q         <= '0;
         lane_q       <= '0;
         address_q    <= '0;
         writedata_q  <= '0;
         byteenable_q <= '0;
         read_q       <= 1'b0;
         write_q      <= 1'b0;
         load_data_q  <= '0;
         misaligned_q <= 1'b0;
         timeout_q    <= 1'b0;
         wait_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         lane_q       <= lane_d;
         address_q    <= address_d;
         writedata_q  <= writedata_d;
         byteenable_q <= byteenable_d;
         read_q       <= read_d;
         write_q      <= write_d;
         load_data_q  <= load_data_d;
         misaligned_q <= misaligned_d;
         timeout_q    <= timeout_d;
         wait_cnt_q   <= wait_cnt_d;
      end
   end

   assign busy       = (state_q != StIdle);
   assign done       = (state_q == StFinish);
   assign load_data  = load_data_q;
   assign misaligned = misaligned_q;
   assign timeout    = timeout_q;
   assign address    = address_q;
   assign read       = read_q;
   assign write      = write_q;
   assign writedata  = writedata_q;
   assign byteenable = byteenable_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed and random loads/stores, each expanded by a
// transaction-level model into a per-cycle expectation that one process compares.
module tb_mem_access_ctrl;

   localparam int unsigned Limit = 4;

   localparam logic [5:0] LB  = 6'b100000;
   localparam logic [5:0] LH  = 6'b100001;
   localparam logic [5:0] LW  = 6'b100011;
   localparam logic [5:0] LBU = 6'b100100;
   localparam logic [5:0] LHU = 6'b100101;
   localparam logic [5:0] SB  = 6'b101000;
   localparam logic [5:0] SH  = 6'b101001;
   localparam logic [5:0] SW  = 6'b101011;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [5:0]  opcode;
   logic [31:0] addr;
   logic [31:0] store_data;
   logic        busy;
   logic        done;
   logic [31:0] load_data;
   logic        misaligned;
   logic        timeout;
   logic [31:0] address;
   logic        read;
   logic        write;
   logic [31:0] writedata;
   logic [3:0]  byteenable;
   logic        waitrequest;
   logic [31:0] readdata;

   always #5 clk = ~clk;

   mem_access_ctrl #(.WAIT_LIMIT(Limit)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .opcode      (opcode),
      .addr        (addr),
      .store_data  (store_data),
      .busy        (busy),
      .done        (done),
      .load_data   (load_data),
      .misaligned  (misaligned),
      .timeout     (timeout),
      .address     (address),
      .read        (read),
      .write       (write),
      .writedata   (writedata),
      .byteenable  (byteenable),
      .waitrequest (waitrequest),
      .readdata    (readdata)
   );

   int          checks = 0;
   int          errors = 0;
   logic        chk_en = 1'b0;

   // Expected values for the current cycle, set by the driver just after each rising edge.
   logic        exp_busy, exp_done, exp_read, exp_write, exp_mis, exp_tmo, exp_ld_valid;
   logic [31:0] exp_addr, exp_wd, model_ld;
   logic [3:0]  exp_be;

   // Observations from the most recent transaction, for literal spot checks.
   logic [31:0] cap_addr, cap_wd;
   logic [3:0]  cap_be;
   int          cap_nstrobe;
   logic        cap_done, cap_mis, cap_tmo;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
      end
   endtask

   // Per-cycle comparison against the model, on the falling edge.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("busy", 32'(busy), 32'(exp_busy));
         chk("done", 32'(done), 32'(exp_done));
         chk("read", 32'(read), 32'(exp_read));
         chk("write", 32'(write), 32'(exp_write));
         if (exp_read || exp_write) begin
            chk("address", address, exp_addr);
            chk("byteenable", 32'(byteenable), 32'(exp_be));
         end
         if (exp_write) chk("writedata", writedata, exp_wd);
         if (exp_done) begin
            chk("misaligned", 32'(misaligned), 32'(exp_mis));
            chk("timeout", 32'(timeout), 32'(exp_tmo));
         end
         if (exp_ld_valid) chk("load_data", load_data, model_ld);
      end
   end

   function automatic int op_size(input logic [5:0] op);
      case (op)
         LB, LBU, SB: return 1;
         LH, LHU, SH: return 2;
         LW, SW:      return 4;
         default:     return 0;
      endcase
   endfunction

   function automatic logic is_load_op(input logic [5:0] op);
      return op inside {LB, LBU, LH, LHU, LW};
   endfunction

   function automatic logic [3:0] model_be(input int sz, input logic [1:0] lane);
      logic [3:0] mask;
      if (sz == 4) return 4'b1111;
      mask = (sz == 1) ? 4'b0001 : 4'b0011;
      return mask << lane;
   endfunction

   function automatic logic [31:0] model_wd(input int sz, input logic [31:0] sd);
      if (sz == 1) return {4{sd[7:0]}};
      if (sz == 2) return {2{sd[15:0]}};
      return sd;
   endfunction

   function automatic logic [31:0] model_load(input logic [5:0] op, input logic [1:0] lane,
                                              input logic [31:0] rd);
      logic [31:0] v;
      v = rd >> (8 * lane);
      case (op)
         LB:      return {{24{v[7]}}, v[7:0]};
         LBU:     return {24'b0, v[7:0]};
         LH:      return {{16{v[15]}}, v[15:0]};
         LHU:     return {16'b0, v[15:0]};
         default: return rd;
      endcase
   endfunction

   function automatic logic [5:0] rand_op();
      case ($urandom_range(0, 7))
         0:       return LB;
         1:       return LH;
         2:       return LW;
         3:       return LBU;
         4:       return LHU;
         5:       return SB;
         6:       return SH;
         default: return SW;
      endcase
   endfunction

   task automatic set_idle();
      exp_busy     = 1'b0;
      exp_done     = 1'b0;
      exp_read     = 1'b0;
      exp_write    = 1'b0;
      exp_mis      = 1'b0;
      exp_tmo      = 1'b0;
      exp_ld_valid = 1'b1;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Noise while the DUT is busy: these inputs must all be ignored.
   task automatic busy_noise();
      start       = 1'($urandom);
      opcode      = rand_op();
      addr        = $urandom;
      store_data  = $urandom;
      waitrequest = 1'($urandom);
      readdata    = $urandom;
   endtask

   // One request: present start in the current (idle) cycle, then walk the expected timeline.
   task automatic run_txn(input logic [5:0] op, input logic [31:0] a, input logic [31:0] sd,
                          input int waits, input logic fix_rd, input logic [31:0] rd);
      int   sz;
      logic ld;
      logic tmo;
      int   n_strobe;
      sz = op_size(op);
      ld = is_load_op(op);
      cap_nstrobe = 0;
      cap_done = 1'b0;
      cap_mis = 1'b0;
      cap_tmo = 1'b0;
      cap_addr = '0;
      cap_be = '0;
      cap_wd = '0;
      start       = 1'b1;
      opcode      = op;
      addr        = a;
      store_data  = sd;
      waitrequest = 1'($urandom);
      readdata    = $urandom;
      set_idle();
      next_cycle();
      if (sz == 0) begin
         start = 1'b0;
         set_idle();
         return;
      end
      if ((int'(a[1:0]) % sz) != 0) begin
         busy_noise();
         set_idle();
         exp_busy = 1'b1;
         exp_done = 1'b1;
         exp_mis  = 1'b1;
         #3;
         cap_done = done;
         cap_mis  = misaligned;
         cap_tmo  = timeout;
         next_cycle();
         start = 1'b0;
         set_idle();
         return;
      end
      tmo      = (Limit != 0) && (waits > int'(Limit));
      n_strobe = tmo ? int'(Limit) + 1 : waits + 1;
      for (int j = 0; j < n_strobe; j++) begin
         busy_noise();
         waitrequest = (j < waits);
         if (fix_rd) readdata = rd;
         set_idle();
         exp_ld_valid = 1'b0;
         exp_busy     = 1'b1;
         exp_read     = ld;
         exp_write    = !ld;
         exp_addr     = {a[31:2], 2'b00};
         exp_be       = model_be(sz, a[1:0]);
         exp_wd       = model_wd(sz, sd);
         if (!tmo && j == waits && ld) model_ld = model_load(op, a[1:0], readdata);
         #3;
         if (read || write) cap_nstrobe++;
         if (j == 0) begin
            cap_addr = address;
            cap_be   = byteenable;
            cap_wd   = writedata;
         end
         next_cycle();
      end
      busy_noise();
      set_idle();
      exp_busy = 1'b1;
      exp_done = 1'b1;
      exp_tmo  = tmo;
      #3;
      cap_done = done;
      cap_mis  = misaligned;
      cap_tmo  = timeout;
      next_cycle();
      start = 1'b0;
      set_idle();
   endtask

   initial begin
      logic [5:0] rop;
      reset       = 1'b1;
      start       = 1'b0;
      opcode      = '0;
      addr        = '0;
      store_data  = '0;
      waitrequest = 1'b0;
      readdata    = '0;
      model_ld    = '0;
      set_idle();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_read", 32'(read), 32'd0);
      chk("rst_write", 32'(write), 32'd0);
      chk("rst_mis", 32'(misaligned), 32'd0);
      chk("rst_tmo", 32'(timeout), 32'd0);
      chk("rst_address", address, 32'd0);
      chk("rst_writedata", writedata, 32'd0);
      chk("rst_byteenable", 32'(byteenable), 32'd0);
      chk("rst_load_data", load_data, 32'd0);
      reset  = 1'b0;
      chk_en = 1'b1;

      // LB, byte 3, sign bit set.
      run_txn(LB, 32'h0000_0403, 32'h0, 0, 1'b1, 32'h80FF_7F01);
      chk("lb_addr", cap_addr, 32'h0000_0400);
      chk("lb_be", 32'(cap_be), 32'h8);
      chk("lb_nstrobe", 32'(cap_nstrobe), 32'd1);
      chk("lb_load", load_data, 32'hFFFF_FF80);

      // LHU, upper half, three wait cycles.
      run_txn(LHU, 32'h0000_1002, 32'h0, 3, 1'b1, 32'h8001_ABCD);
      chk("lhu_addr", cap_addr, 32'h0000_1000);
      chk("lhu_be", 32'(cap_be), 32'hC);
      chk("lhu_nstrobe", 32'(cap_nstrobe), 32'd4);
      chk("lhu_load", load_data, 32'h0000_8001);

      // SB replicates the byte; load_data stays as it was.
      run_txn(SB, 32'h0000_0021, 32'h1234_56AB, 0, 1'b0, 32'h0);
      chk("sb_be", 32'(cap_be), 32'h2);
      chk("sb_wd", cap_wd, 32'hABAB_ABAB);
      chk("sb_done", 32'(cap_done), 32'd1);
      chk("sb_load", load_data, 32'h0000_8001);

      // Misaligned word and halfword: no strobe, done with misaligned one cycle after start.
      run_txn(SW, 32'h0000_0022, 32'hCAFE_F00D, 0, 1'b0, 32'h0);
      chk("sw_mis", 32'(cap_mis), 32'd1);
      chk("sw_done", 32'(cap_done), 32'd1);
      run_txn(LH, 32'h0000_0023, 32'h0, 0, 1'b0, 32'h0);
      chk("lh_mis", 32'(cap_mis), 32'd1);

      // Unsupported opcode is ignored.
      run_txn(6'b000000, 32'h0000_0010, 32'h0, 0, 1'b0, 32'h0);
      next_cycle();

      // Stuck waitrequest times out; counter hitting the limit as waitrequest falls completes.
      run_txn(LW, 32'h0000_0100, 32'h0, 50, 1'b1, 32'h1111_2222);
      chk("to_tmo", 32'(cap_tmo), 32'd1);
      chk("to_nstrobe", 32'(cap_nstrobe), 32'd5);
      chk("to_load", load_data, 32'h0000_8001);
      run_txn(LW, 32'h0000_0104, 32'h0, 4, 1'b1, 32'h3333_4444);
      chk("edge_tmo", 32'(cap_tmo), 32'd0);
      chk("edge_load", load_data, 32'h3333_4444);

      // Reset during the second wait cycle of a load.
      start = 1'b1;
      opcode = LW;
      addr = 32'h0000_0040;
      set_idle();
      next_cycle();
      start = 1'b0;
      waitrequest = 1'b1;
      set_idle();
      exp_busy = 1'b1;
      exp_read = 1'b1;
      exp_ld_valid = 1'b0;
      exp_addr = 32'h0000_0040;
      exp_be = 4'hF;
      next_cycle();
      #2;
      chk_en = 1'b0;
      reset  = 1'b1;
      #1;
      chk("arst_read", 32'(read), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_done", 32'(done), 32'd0);
      next_cycle();
      reset = 1'b0;
      waitrequest = 1'b0;
      model_ld = '0;
      set_idle();
      chk_en = 1'b1;
      next_cycle();
      run_txn(LW, 32'h0000_0008, 32'h0, 0, 1'b1, 32'hDEAD_BEEF);
      chk("post_rst_load", load_data, 32'hDEAD_BEEF);

      // Random traffic, including misaligned, unsupported and timed-out requests.
      repeat (150) begin
         if ($urandom_range(0, 9) == 0) begin
            do rop = 6'($urandom); while (op_size(rop) != 0);
         end else begin
            rop = rand_op();
         end
         run_txn(rop, $urandom, $urandom, int'($urandom_range(0, 6)), 1'b0, 32'h0);
         repeat ($urandom_range(0, 2)) begin
            waitrequest = 1'($urandom);
            readdata = $urandom;
            next_cycle();
         end
      end

      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
